// File: rtl/fp_conv_pkg.sv
// Shared types and constants for the FP16/BF16 -> FP32 widening converter.
// Exponent constants are derived from the two format biases.
package fp_conv_pkg;

  typedef enum logic {
    FMT_FP16 = 1'b0,
    FMT_BF16 = 1'b1
  } fmt_e;

  localparam int FP16_BIAS             = 15;
  localparam int FP32_BIAS             = 127;
  localparam int FP16_TO_FP32_BIAS_ADJ = FP32_BIAS - FP16_BIAS;
  // A subnormal with leading one at bit p has true exponent p-24, so its FP32 exponent is p+103.
  localparam int SUBNORM_EXP_BASE      = FP16_TO_FP32_BIAS_ADJ - 9;
  localparam int FP32_QUIET_BIT        = 22;

endpackage

// File: rtl/fp_lane_to_fp32.sv
// One lane of the widening converter: a 16-bit FP16 or BF16 value to FP32, plus an sNaN flag.
// Purely combinational; the top registers around it.
module fp_lane_to_fp32
  import fp_conv_pkg::*;
#(
  parameter bit QUIET_SNAN = 1'b1
) (
  input  logic [15:0] i_data,
  input  fmt_e        i_fmt,
  output logic [31:0] o_fp32,
  output logic        o_is_snan
);

  logic       w_sign;
  logic [4:0] w_e16;
  logic [9:0] w_m16;
  logic [3:0] w_lead_pos;
  logic [9:0] w_sub_mant;
  logic [7:0] w_sub_exp;
  logic [7:0] w_norm_exp;
  logic       w_bf16_nan;

  assign w_sign = i_data[15];
  assign w_e16  = i_data[14:10];
  assign w_m16  = i_data[9:0];

  fp_leading_one #(.LEN(10)) u_lead (
    .i_vec (w_m16),
    .o_pos (w_lead_pos)
  );

  // Shifting the leading one out of the 10-bit field leaves the normalised fraction.
  assign w_sub_mant = w_m16 << (4'd10 - w_lead_pos);
  assign w_sub_exp  = 8'(SUBNORM_EXP_BASE) + {4'd0, w_lead_pos};
  assign w_norm_exp = {3'd0, w_e16} + 8'(FP16_TO_FP32_BIAS_ADJ);
  assign w_bf16_nan = (&i_data[14:7]) & (|i_data[6:0]);

  always_comb begin
    o_fp32    = '0;
    o_is_snan = 1'b0;
    if (i_fmt == FMT_BF16) begin
      o_fp32 = {i_data, 16'h0000};
      if (w_bf16_nan) begin
        o_is_snan = ~i_data[6];
        if (QUIET_SNAN) o_fp32[FP32_QUIET_BIT] = 1'b1;
      end
    end else if (w_e16 == 5'd0) begin
      if (w_m16 == 10'd0) o_fp32 = {w_sign, 31'd0};
      else                o_fp32 = {w_sign, w_sub_exp, w_sub_mant, 13'd0};
    end else if (w_e16 == 5'h1F) begin
      o_fp32 = {w_sign, 8'hFF, w_m16, 13'd0};
      if (w_m16 != 10'd0) begin
        o_is_snan = ~w_m16[9];
        if (QUIET_SNAN) o_fp32[FP32_QUIET_BIT] = 1'b1;
      end
    end else begin
      o_fp32 = {w_sign, w_norm_exp, w_m16, 13'd0};
    end
  end

endmodule

// File: rtl/fp_leading_one.sv
// Priority encoder: index of the most significant set bit of i_vec (0 when i_vec is zero).
module fp_leading_one #(
  parameter int LEN = 10,
  parameter int PW  = $clog2(LEN)
) (
  input  logic [LEN-1:0] i_vec,
  output logic [PW-1:0]  o_pos
);

  always_comb begin
    o_pos = '0;
    for (int i = 0; i < LEN; i++) begin
      if (i_vec[i]) o_pos = PW'(i);
    end
  end

endmodule

// File: rtl/fp_to_fp32_convert_pipe.sv
// LANES x {FP16|BF16} -> LANES x FP32 converter with valid/ready flow control.
// The whole pipeline advances together; a sticky flag records any accepted signalling NaN.
module fp_to_fp32_convert_pipe
  import fp_conv_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int LATENCY    = 2,
  parameter bit QUIET_SNAN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_fmt_i,
  input  logic [LANES*16-1:0]   in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES*32-1:0]   out_data_o,
  output logic                  snan_seen_o,
  input  logic                  clear_i
);

  logic                  w_advance;
  logic                  w_accept;
  logic                  r_s1_valid;
  fmt_e                  r_s1_fmt;
  logic [LANES*16-1:0]   r_s1_data;
  logic                  r_s1_new;
  logic [LANES*32-1:0]   w_conv;
  logic [LANES-1:0]      w_lane_snan;
  logic                  r_snan;

  assign w_advance  = ~out_valid_o | out_ready_i;
  assign in_ready_o = w_advance;
  assign w_accept   = in_valid_i & w_advance;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_fmt   <= FMT_FP16;
      r_s1_data  <= '0;
      r_s1_new   <= 1'b0;
    end else begin
      r_s1_new <= w_accept;
      if (w_advance) begin
        r_s1_valid <= in_valid_i;
        if (in_valid_i) begin
          r_s1_fmt  <= fmt_e'(in_fmt_i);
          r_s1_data <= in_data_i;
        end
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fp_lane_to_fp32 #(.QUIET_SNAN(QUIET_SNAN)) u_lane (
      .i_data    (r_s1_data[16*k +: 16]),
      .i_fmt     (r_s1_fmt),
      .o_fp32    (w_conv[32*k +: 32]),
      .o_is_snan (w_lane_snan[k])
    );
  end

  // Stage 1 holds the beat accepted last cycle while r_s1_new is high, so the sticky flag
  // becomes visible exactly one cycle after the accept without a second set of detectors.
  assign snan_seen_o = r_snan | (r_s1_new & (|w_lane_snan));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_snan <= 1'b0;
    else       r_snan <= snan_seen_o & ~clear_i;
  end

  if (LATENCY >= 2) begin : g_lat2
    logic                r_s2_valid;
    logic [LANES*32-1:0] r_s2_data;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_s2_valid <= 1'b0;
        r_s2_data  <= '0;
      end else if (w_advance) begin
        r_s2_valid <= r_s1_valid;
        r_s2_data  <= w_conv;
      end
    end

    assign out_valid_o = r_s2_valid;
    assign out_data_o  = r_s2_data;
  end else begin : g_lat1
    assign out_valid_o = r_s1_valid;
    assign out_data_o  = w_conv;
  end

endmodule

// File: tb/tb_fp_to_fp32_convert_pipe.sv
// Directed bench for fp_to_fp32_convert_pipe (LANES=4, LATENCY=2, QUIET_SNAN=1).
// Inputs change and outputs are sampled on the falling edge.
module tb_fp_to_fp32_convert_pipe;

  localparam int LANES = 4;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                in_valid_i = 1'b0;
  logic                in_ready_o;
  logic                in_fmt_i = 1'b0;
  logic [LANES*16-1:0] in_data_i = '0;
  logic                out_valid_o;
  logic                out_ready_i = 1'b1;
  logic [LANES*32-1:0] out_data_o;
  logic                snan_seen_o;
  logic                clear_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Backpressure tables: row 0 FP16, row 1 BF16, with hand-converted FP32 results.
  logic [15:0] bp_tab_in [2][8] = '{
    '{16'h3C00, 16'hC000, 16'h8000, 16'h0001, 16'h03FF, 16'h0200, 16'hFC00, 16'h7E00},
    '{16'h4049, 16'hFF81, 16'h3F80, 16'h0000, 16'h8000, 16'h7F80, 16'h0001, 16'hC2F7}};
  logic [31:0] bp_tab_out [2][8] = '{
    '{32'h3F800000, 32'hC0000000, 32'h80000000, 32'h33800000,
      32'h387FC000, 32'h38000000, 32'hFF800000, 32'h7FC00000},
    '{32'h40490000, 32'hFFC10000, 32'h3F800000, 32'h00000000,
      32'h80000000, 32'h7F800000, 32'h00010000, 32'hC2F70000}};

  fp_to_fp32_convert_pipe #(.LANES(LANES), .LATENCY(2), .QUIET_SNAN(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_fmt_i    (in_fmt_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .snan_seen_o (snan_seen_o),
    .clear_i     (clear_i)
  );

  initial forever #5 clk_i = ~clk_i;

  function automatic logic [63:0] bp_in(input int b);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[16*k +: 16] = bp_tab_in[b % 2][(b + k) % 8];
    return r;
  endfunction

  function automatic logic [127:0] bp_exp(input int b);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[32*k +: 32] = bp_tab_out[b % 2][(b + k) % 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic fmt, input logic [63:0] data);
    in_valid_i = 1'b1;
    in_fmt_i   = fmt;
    in_data_i  = data;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [127:0] exp);
    int n;
    n = 0;
    while (out_valid_o !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 128'(out_valid_o), 128'(1'b1));
    check(tag, out_data_o, exp);
    tick();
  endtask

  initial begin
    int tx;
    int rx;

    repeat (3) tick();
    rst_i = 1'b0;
    check("rst_out_valid", 128'(out_valid_o), 128'(1'b0));
    check("rst_out_data", out_data_o, 128'h0);
    check("rst_snan", 128'(snan_seen_o), 128'(1'b0));
    check("rst_in_ready", 128'(in_ready_o), 128'(1'b1));

    // FP16 normals, zeros and smallest subnormal; latency must be exactly two cycles.
    send(1'b0, {16'h0001, 16'h8000, 16'hC000, 16'h3C00});
    check("lat_cycle1", 128'(out_valid_o), 128'(1'b0));
    tick();
    check("lat_cycle2", 128'(out_valid_o), 128'(1'b1));
    check("fp16_norm", out_data_o,
          {32'h33800000, 32'h80000000, 32'hC0000000, 32'h3F800000});
    tick();
    check("single_beat_once", 128'(out_valid_o), 128'(1'b0));

    send(1'b0, {16'h7E00, 16'hFC00, 16'h0200, 16'h03FF});
    check("no_snan_qnan", 128'(snan_seen_o), 128'(1'b0));
    expect_beat("fp16_sub_spec", {32'h7FC00000, 32'hFF800000, 32'h38000000, 32'h387FC000});

    send(1'b0, {16'h0400, 16'h7C00, 16'h0000, 16'h7C01});
    check("snan_fp16_set", 128'(snan_seen_o), 128'(1'b1));
    expect_beat("fp16_snan", {32'h38800000, 32'h7F800000, 32'h00000000, 32'h7FC02000});
    check("snan_sticky", 128'(snan_seen_o), 128'(1'b1));
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("snan_clear", 128'(snan_seen_o), 128'(1'b0));

    send(1'b1, {16'h0001, 16'h7FC0, 16'hFF81, 16'h4049});
    check("snan_bf16_set", 128'(snan_seen_o), 128'(1'b1));
    expect_beat("bf16", {32'h00010000, 32'h7FC00000, 32'hFFC10000, 32'h40490000});
    clear_i = 1'b1;
    tick();
    check("snan_clear2", 128'(snan_seen_o), 128'(1'b0));

    // Clear together with an sNaN accept: set wins.
    in_valid_i = 1'b1;
    in_fmt_i   = 1'b0;
    in_data_i  = {16'h3C00, 16'h3C00, 16'h3C00, 16'h7C01};
    tick();
    in_valid_i = 1'b0;
    clear_i    = 1'b0;
    check("snan_set_wins", 128'(snan_seen_o), 128'(1'b1));
    repeat (3) tick();
    check("snan_hold", 128'(snan_seen_o), 128'(1'b1));

    // Same bits interpreted as FP16 then BF16 on consecutive beats.
    in_valid_i = 1'b1;
    in_fmt_i   = 1'b0;
    in_data_i  = {4{16'h3C00}};
    tick();
    in_fmt_i   = 1'b1;
    tick();
    in_valid_i = 1'b0;
    expect_beat("mixed_fp16", {4{32'h3F800000}});
    check("mixed_b2b", 128'(out_valid_o), 128'(1'b1));
    expect_beat("mixed_bf16", {4{32'h3C000000}});

    // Backpressure: 8 back-to-back beats, alternating format, random downstream ready.
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 300 && rx < 8; cyc++) begin
      out_ready_i = 1'($urandom_range(0, 1));
      if (tx < 8) begin
        in_valid_i = 1'b1;
        in_fmt_i   = (tx % 2 == 1);
        in_data_i  = bp_in(tx);
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (out_valid_o === 1'b1) begin
        check("bp_data", out_data_o, bp_exp(rx));
        if (out_ready_i) rx++;
      end
      if (in_valid_i && in_ready_o) tx++;
      tick();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    check("bp_all_sent", 128'(32'(tx)), 128'(32'd8));
    check("bp_all_recv", 128'(32'(rx)), 128'(32'd8));
    repeat (3) begin
      tick();
      check("bp_no_dup", 128'(out_valid_o), 128'(1'b0));
    end

    // Reset with two beats in flight.
    in_valid_i = 1'b1;
    in_fmt_i   = 1'b0;
    in_data_i  = {16'h0400, 16'h7C00, 16'h0000, 16'h7C01};
    tick();
    in_data_i  = {16'h0001, 16'h8000, 16'hC000, 16'h3C00};
    tick();
    in_valid_i = 1'b0;
    check("inflight_valid", 128'(out_valid_o), 128'(1'b1));
    check("inflight_snan", 128'(snan_seen_o), 128'(1'b1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_snan", 128'(snan_seen_o), 128'(1'b0));
    repeat (4) begin
      check("midrst_no_out", 128'(out_valid_o), 128'(1'b0));
      tick();
    end
    send(1'b1, {16'h4049, 16'h4049, 16'h4049, 16'h4049});
    expect_beat("post_rst", {4{32'h40490000}});
    check("post_rst_snan", 128'(snan_seen_o), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
